// File: rtl/cluster_clock_div_sel_if.sv
// cluster_clock_div_sel_if: divide-ratio request handshake plus readback of the ratio in effect
interface cluster_clock_div_sel_if #(parameter int DIV_W = 8);
  logic [DIV_W-1:0] div_i;
  logic             div_valid_i;
  logic             div_ready_o;
  logic [DIV_W-1:0] div_o;
  modport master (output div_i, div_valid_i, input div_ready_o, div_o);
  modport slave  (input div_i, div_valid_i, output div_ready_o, div_o);
endinterface

// File: rtl/cluster_clock_div_sel.sv
// cluster_clock_div_sel: glitch-free programmable clock divider with bypass, ratio changes at period boundaries
module cluster_clock_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic sel_i,
  output logic clk_o
);
  assign clk_o = sel_i ? clk1_i : clk0_i;
endmodule

module cluster_clock_div_sel #(
  parameter int          DIV_W   = 8,
  parameter int unsigned DIV_RST = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  cluster_clock_div_sel_if.slave  div_if,
  output logic                    clk_o
);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RST);
  localparam logic             RST_BYP = RST_DIV < DIV_W'(2);
  logic [DIV_W-1:0] r_cnt, r_div, r_div_pend;
  logic             r_clk_div, r_pend, r_sel_n;
  logic [DIV_W-1:0] w_cnt_nxt, w_div_nxt, w_div_pend_nxt;
  logic             w_bypass, w_boundary, w_apply, w_accept, w_pend_nxt, w_clk_div_nxt;
  // Next-state: a pending ratio only takes over at a period boundary; the divided clock stays low
  // while bypass is in effect or still selected so its first high phase follows the mux switch.
  always_comb begin
    w_bypass       = r_div < DIV_W'(2);
    w_boundary     = w_bypass | (r_cnt == r_div - DIV_W'(1));
    w_apply        = r_pend & w_boundary;
    w_accept       = div_if.div_valid_i & ~r_pend;
    w_div_nxt      = w_apply ? r_div_pend : r_div;
    w_pend_nxt     = w_apply ? 1'b0 : (w_accept | r_pend);
    w_div_pend_nxt = w_accept ? div_if.div_i : r_div_pend;
    w_cnt_nxt      = w_boundary ? '0 : r_cnt + DIV_W'(1);
    w_clk_div_nxt  = (w_div_nxt >= DIV_W'(2)) & ~r_sel_n & (w_cnt_nxt < (w_div_nxt >> 1));
  end
  // Divider counter, ratio registers and request holding register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= '0;
      r_div      <= RST_DIV;
      r_div_pend <= '0;
      r_pend     <= 1'b0;
      r_clk_div  <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_div      <= w_div_nxt;
      r_div_pend <= w_div_pend_nxt;
      r_pend     <= w_pend_nxt;
      r_clk_div  <= w_clk_div_nxt;
    end
  end
  // Mux select moves only on a falling source edge with the divided clock low, so both mux inputs are low.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sel_n <= RST_BYP;
    else if (!r_clk_div) r_sel_n <= w_bypass | test_mode_i;
  end
  assign div_if.div_ready_o = ~r_pend;
  assign div_if.div_o       = r_div;
  cluster_clock_mux2 u_mux (
    .clk0_i (r_clk_div),
    .clk1_i (clk_i),
    .sel_i  (r_sel_n),
    .clk_o  (clk_o)
  );
endmodule

// File: tb/tb_cluster_clock_div_sel.sv
// tb_cluster_clock_div_sel: table-driven ratio sweep with scoreboard plus hand-written corner sequences
module tb_cluster_clock_div_sel;
  localparam int DIV_W = 8;
  logic clk_i = 1'b0, rst_ni = 1'b0, test_mode_i = 1'b0, clk_o;
  int n_cmp = 0, n_err = 0;
  cluster_clock_div_sel_if #(.DIV_W(DIV_W)) bus ();
  cluster_clock_div_sel #(.DIV_W(DIV_W), .DIV_RST(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .div_if(bus), .clk_o(clk_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct { logic [7:0] div; bit byp; int hi; int lo; } vec_t;
  vec_t vecs[9];
  vec_t sb[$];
  logic mon_en = 1'b0, have = 1'b0;
  time  t_last = 0, min_hi = 1000, min_lo = 1000;
  always @(clk_o) begin
    if (!mon_en) have = 1'b0;
    else begin
      if (have && clk_o === 1'b0 && $time - t_last < min_hi) min_hi = $time - t_last;
      if (have && clk_o === 1'b1 && $time - t_last < min_lo) min_lo = $time - t_last;
      have = 1'b1;
      t_last = $time;
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic step(output logic v);
    @(posedge clk_i); #1; v = clk_o;
  endtask
  task automatic wait_div(input logic [7:0] d);
    int n = 0;
    while (bus.div_o !== d && n < 600) begin @(posedge clk_i); #1; n++; end
    chk("div_o_reached", bus.div_o, d);
  endtask
  task automatic wait_edge(input logic to);
    logic prev, cur;
    int n = 0;
    step(prev); step(cur);
    while (!(prev == !to && cur == to) && n < 1200) begin prev = cur; step(cur); n++; end
    chk("edge_seen", n < 1200, 1);
  endtask
  task automatic request(input logic [7:0] d);
    int n = 0;
    @(negedge clk_i);
    while (bus.div_ready_o !== 1'b1 && n < 600) begin @(negedge clk_i); n++; end
    bus.div_i = d;
    bus.div_valid_i = 1'b1;
    @(posedge clk_i); #1;
    bus.div_valid_i = 1'b0;
    chk("ready_low_after_accept", bus.div_ready_o, 0);
  endtask
  task automatic chk_bypass(input string name);
    logic [5:0] p;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #2; p[5-2*i] = clk_o;
      @(negedge clk_i); #2; p[4-2*i] = clk_o;
    end
    chk(name, p, 6'b101010);
  endtask
  task automatic measure(output int hi, output int lo);
    logic prev, cur;
    int rises = 0, n = 0;
    hi = 0; lo = 0;
    step(prev);
    while (rises < 2 && n < 1200) begin step(cur); if (!prev && cur) rises++; prev = cur; n++; end
    if (rises < 2) return;
    hi = 1;
    while (n < 2400) begin
      step(cur); n++;
      if (cur) begin if (lo > 0) break; hi++; end
      else lo++;
    end
  endtask
  task automatic check_out();
    vec_t e;
    int hi, lo;
    e = sb.pop_front();
    wait_div(e.div);
    if (e.byp) begin
      repeat (2) @(posedge clk_i);
      chk_bypass($sformatf("bypass_div%0d", e.div));
    end else begin
      measure(hi, lo);
      chk($sformatf("high_cycles_div%0d", e.div), hi, e.hi);
      chk($sformatf("low_cycles_div%0d", e.div), lo, e.lo);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic v;
    logic [4:0] pat;
    int hi, lo;
    bus.div_i = '0;
    bus.div_valid_i = 1'b0;
    vecs[0] = '{8'd3,   1'b0, 1,   2};
    vecs[1] = '{8'd5,   1'b0, 2,   3};
    vecs[2] = '{8'd6,   1'b0, 3,   3};
    vecs[3] = '{8'd0,   1'b1, 0,   0};
    vecs[4] = '{8'd2,   1'b0, 1,   1};
    vecs[5] = '{8'd8,   1'b0, 4,   4};
    vecs[6] = '{8'd1,   1'b1, 0,   0};
    vecs[7] = '{8'd255, 1'b0, 127, 128};
    vecs[8] = '{8'd7,   1'b0, 3,   4};
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    chk("rst_div_o", bus.div_o, 1);
    chk("rst_ready", bus.div_ready_o, 1);
    chk_bypass("rst_bypass");
    mon_en = 1'b1;
    request(8'd4);
    step(v);
    chk("ready_back_after_one_cycle", bus.div_ready_o, 1);
    chk("div4_applied", bus.div_o, 4);
    measure(hi, lo);
    chk("high_cycles_div4", hi, 2);
    chk("low_cycles_div4", lo, 2);
    foreach (vecs[i]) begin
      request(vecs[i].div);
      sb.push_back(vecs[i]);
      check_out();
    end
    request(8'd3);
    wait_div(8'd3);
    wait_edge(1'b1);
    step(v);
    @(negedge clk_i);
    bus.div_i = 8'd5;
    bus.div_valid_i = 1'b1;
    @(posedge clk_i); #1;
    chk("mid_period_clk_low", clk_o, 0);
    chk("mid_period_div_still3", bus.div_o, 3);
    chk("mid_period_ready_low", bus.div_ready_o, 0);
    bus.div_i = 8'd7;
    step(v);
    bus.div_valid_i = 1'b0;
    chk("wrap_div_now5", bus.div_o, 5);
    chk("wrap_clk_rises", v, 1);
    chk("wrap_ready_high", bus.div_ready_o, 1);
    for (int i = 0; i < 5; i++) begin step(v); pat[4-i] = v; end
    chk("div5_pattern", pat, 5'b10001);
    repeat (20) @(posedge clk_i);
    chk("ignored_request_not_queued", bus.div_o, 5);
    request(8'd8);
    wait_div(8'd8);
    wait_edge(1'b0);
    test_mode_i = 1'b1;
    chk_bypass("test_mode_bypass");
    chk("test_mode_div_o", bus.div_o, 8);
    test_mode_i = 1'b0;
    repeat (3) @(posedge clk_i);
    measure(hi, lo);
    chk("high_cycles_after_test_mode", hi, 4);
    chk("low_cycles_after_test_mode", lo, 4);
    wait_edge(1'b1);
    @(negedge clk_i);
    bus.div_i = 8'd13;
    bus.div_valid_i = 1'b1;
    @(posedge clk_i); #1;
    bus.div_valid_i = 1'b0;
    chk("pre_reset_pending", bus.div_ready_o, 0);
    chk("pre_reset_high_phase", clk_o, 1);
    #1;
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("reset_div_o", bus.div_o, 1);
    chk("reset_ready", bus.div_ready_o, 1);
    chk_bypass("in_reset_bypass");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    chk("post_reset_request_lost", bus.div_o, 1);
    chk("post_reset_ready", bus.div_ready_o, 1);
    chk_bypass("post_reset_bypass");
    chk("min_high_width_ge_half_period", min_hi >= 5, 1);
    chk("min_low_width_ge_half_period", min_lo >= 5, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
